// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
package pc_seq_pkg;
  typedef enum logic {RUN, PAUSED} state_t;
  typedef enum logic [1:0] {SEQ, BR, J, JR} npc_sel_t;
  localparam logic [31:0] DEF_CONT_CODE = 32'h0000_0022;
endpackage

// File: rtl/go_edge_sync.sv
// Brings the asynchronous go button into the clk domain and flags each rising edge once.
module go_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic go_rise
);
  logic g1, g2, g3;

  always_ff @(posedge clk) begin
    if (rst) begin
      g1 <= 1'b0;
      g2 <= 1'b0;
      g3 <= 1'b0;
    end else begin
      g1 <= go;
      g2 <= g1;
      g3 <= g2;
    end
  end

  // g1 may be metastable; edge detect only looks at the settled pair
  assign go_rise = g2 & ~g3;
endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC selection, syscall pause/resume on go, and performance counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       CONT_CODE = DEF_CONT_CODE,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              syscall,
  input  logic [31:0]       sys_code,
  input  logic              go,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jr,
  input  logic [25:0]       instr_index,
  input  logic [31:0]       branch_off,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_en,
  output logic              paused,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);
  state_t            state, state_nxt;
  npc_sel_t          sel;
  logic              go_rise, pend_go, halt_req;
  logic [ADDR_W-1:0] pc_nxt, j_target;

  go_edge_sync u_go_sync (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .go_rise (go_rise)
  );

  assign pc_plus4 = pc + ADDR_W'(4);
  assign halt_req = syscall & (sys_code != CONT_CODE);
  assign paused   = (state == PAUSED);

  // Jump keeps the upper PC region only when the PC is wide enough to have one
  if (ADDR_W > 28) begin : g_jhi
    assign j_target = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00};
  end else begin : g_jlo
    assign j_target = ADDR_W'({instr_index, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    sel       = SEQ;
    case (state)
      RUN: begin
        pc_en = ~stall & ~halt_req;
        if (~stall & halt_req) state_nxt = PAUSED;
        if (jr)                sel = JR;
        else if (jump)         sel = J;
        else if (branch_taken) sel = BR;
      end
      PAUSED: begin
        // resume is always sequential, so sel stays SEQ
        pc_en = ~stall & (go_rise | pend_go);
        if (pc_en) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) pc_en = 1'b0;
  end

  always_comb begin
    case (sel)
      JR:      pc_nxt = jr_target;
      J:       pc_nxt = j_target;
      BR:      pc_nxt = pc_plus4 + branch_off[ADDR_W-1:0];
      default: pc_nxt = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      pend_go   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (pc_en) pc <= pc_nxt;
      // a go edge that lands while stalled in PAUSED is held until the stall drops
      if (pc_en)                                 pend_go <= 1'b0;
      else if (state == PAUSED && stall && go_rise) pend_go <= 1'b1;
      if (state == RUN)           cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_en)                  instr_cnt <= instr_cnt + 1'b1;
      if (pc_en && sel != SEQ)    xfer_cnt  <= xfer_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default build plus a narrow-counter, wrapping-PC build.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, syscall, go, branch_taken, jump, jr;
  logic [31:0] sys_code, branch_off, jr_target;
  logic [25:0] instr_index;

  logic [31:0] pc, pc_plus4, cycle_cnt, instr_cnt, xfer_cnt;
  logic        pc_en, paused;
  logic [31:0] pc_w, pc_plus4_w;
  logic [3:0]  cycle_w, instr_w, xfer_w;
  logic        pc_en_w, paused_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .syscall(syscall), .sys_code(sys_code),
    .go(go), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .instr_index(instr_index), .branch_off(branch_off), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .pc_en(pc_en), .paused(paused),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .xfer_cnt(xfer_cnt)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .syscall(syscall), .sys_code(sys_code),
    .go(go), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .instr_index(instr_index), .branch_off(branch_off), .jr_target(jr_target),
    .pc(pc_w), .pc_plus4(pc_plus4_w), .pc_en(pc_en_w), .paused(paused_w),
    .cycle_cnt(cycle_w), .instr_cnt(instr_w), .xfer_cnt(xfer_w)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; syscall = 1'b0; sys_code = '0; go = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; instr_index = '0;
    branch_off = '0; jr_target = '0;
    tick(2);
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    tests++; if (pc_plus4 !== 32'h4) begin fails++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL reset_paused: got %b want 0", paused); end
    tests++; if ({cycle_cnt, instr_cnt, xfer_cnt} !== 96'h0) begin fails++; $display("FAIL reset_cnts: got %h %h %h want 0", cycle_cnt, instr_cnt, xfer_cnt); end
    tests++; if (pc_w !== 32'hFFFF_FFF8) begin fails++; $display("FAIL reset_pc_w: got %h want %h", pc_w, 32'hFFFF_FFF8); end
    rst = 1'b0;
    #1;
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL run_pc_en: got %b want 1", pc_en); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (pc !== 32'(i * 4)) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(i * 4)); end
    end
    tests++; if (instr_cnt !== 32'd4 || cycle_cnt !== 32'd4 || xfer_cnt !== 32'd0) begin
      fails++; $display("FAIL seq_cnts: got c=%0d i=%0d x=%0d want 4 4 0", cycle_cnt, instr_cnt, xfer_cnt); end
  endtask

  task automatic test_transfers();
    // pc=0x10: backward branch by 8 from pc+4
    branch_taken = 1'b1; branch_off = 32'hFFFF_FFF8;
    tick();
    tests++; if (pc !== 32'h0C) begin fails++; $display("FAIL branch_pc: got %h want %h", pc, 32'h0C); end
    // jr beats branch
    jr = 1'b1; jr_target = 32'h40;
    tick();
    tests++; if (pc !== 32'h40) begin fails++; $display("FAIL jr_prio_pc: got %h want %h", pc, 32'h40); end
    // jump beats branch
    jr = 1'b0; jump = 1'b1; instr_index = 26'h100;
    tick();
    tests++; if (pc !== 32'h400) begin fails++; $display("FAIL jump_pc: got %h want %h", pc, 32'h400); end
    // jr beats jump
    jr = 1'b1; jr_target = 32'h20;
    tick();
    tests++; if (pc !== 32'h20) begin fails++; $display("FAIL jr_over_j_pc: got %h want %h", pc, 32'h20); end
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tests++; if (xfer_cnt !== 32'd4 || instr_cnt !== 32'd8 || cycle_cnt !== 32'd8) begin
      fails++; $display("FAIL xfer_cnts: got c=%0d i=%0d x=%0d want 8 8 4", cycle_cnt, instr_cnt, xfer_cnt); end
  endtask

  task automatic test_syscall_cont();
    syscall = 1'b1; sys_code = 32'h22;
    #1;
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL cont_pc_en: got %b want 1", pc_en); end
    tick();
    tests++; if (pc !== 32'h24 || paused !== 1'b0) begin fails++; $display("FAIL cont_pc: got pc=%h paused=%b want 24 0", pc, paused); end
    syscall = 1'b0; jr = 1'b1; jr_target = 32'h20;
    tick();
    jr = 1'b0;
    tests++; if (pc !== 32'h20) begin fails++; $display("FAIL cont_back: got %h want %h", pc, 32'h20); end
  endtask

  task automatic test_pause_go();
    syscall = 1'b1; sys_code = 32'h0A;
    #1;
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL halt_pc_en: got %b want 0", pc_en); end
    tick();
    tests++; if (pc !== 32'h20 || paused !== 1'b1) begin fails++; $display("FAIL halt_enter: got pc=%h paused=%b want 20 1", pc, paused); end
    // selects must be ignored on resume
    jr = 1'b1; jr_target = 32'h80; branch_taken = 1'b1;
    tick(3);
    tests++; if (pc !== 32'h20 || paused !== 1'b1 || cycle_cnt !== 32'd11 || instr_cnt !== 32'd10) begin
      fails++; $display("FAIL halt_hold: got pc=%h p=%b c=%0d i=%0d want 20 1 11 10", pc, paused, cycle_cnt, instr_cnt); end
    go = 1'b1;
    tick();
    go = 1'b0;
    tests++; if (pc !== 32'h20 || pc_en !== 1'b0) begin fails++; $display("FAIL go_e1: got pc=%h en=%b want 20 0", pc, pc_en); end
    tick();
    tests++; if (pc !== 32'h20 || pc_en !== 1'b1) begin fails++; $display("FAIL go_e2: got pc=%h en=%b want 20 1", pc, pc_en); end
    tick();
    tests++; if (pc !== 32'h24 || paused !== 1'b0) begin fails++; $display("FAIL go_resume: got pc=%h paused=%b want 24 0", pc, paused); end
    syscall = 1'b0; jr = 1'b0; branch_taken = 1'b0;
    tests++; if (xfer_cnt !== 32'd5 || instr_cnt !== 32'd11 || cycle_cnt !== 32'd11) begin
      fails++; $display("FAIL resume_cnts: got c=%0d i=%0d x=%0d want 11 11 5", cycle_cnt, instr_cnt, xfer_cnt); end
  endtask

  task automatic test_go_held();
    go = 1'b1;
    tick(20);
    tests++; if (pc !== 32'h74) begin fails++; $display("FAIL held_run_pc: got %h want %h", pc, 32'h74); end
    syscall = 1'b1;
    tick();
    tick(5);
    tests++; if (pc !== 32'h74 || paused !== 1'b1 || pc_en !== 1'b0) begin
      fails++; $display("FAIL held_no_rise: got pc=%h p=%b en=%b want 74 1 0", pc, paused, pc_en); end
    go = 1'b0;
    tick(3);
    go = 1'b1;
    tick(2);
    tests++; if (pc_en !== 1'b1 || pc !== 32'h74) begin fails++; $display("FAIL held_rerise: got pc=%h en=%b want 74 1", pc, pc_en); end
    tick();
    syscall = 1'b0; go = 1'b0;
    tests++; if (pc !== 32'h78 || paused !== 1'b0 || instr_cnt !== 32'd32 || cycle_cnt !== 32'd32) begin
      fails++; $display("FAIL held_resume: got pc=%h p=%b i=%0d c=%0d want 78 0 32 32", pc, paused, instr_cnt, cycle_cnt); end
  endtask

  task automatic test_stall_pause();
    stall = 1'b1;
    tick(2);
    tests++; if (pc !== 32'h78 || pc_en !== 1'b0 || cycle_cnt !== 32'd34 || instr_cnt !== 32'd32) begin
      fails++; $display("FAIL stall_run: got pc=%h en=%b c=%0d i=%0d want 78 0 34 32", pc, pc_en, cycle_cnt, instr_cnt); end
    // halting syscall under stall must not pause
    syscall = 1'b1; sys_code = 32'h0A;
    tick();
    tests++; if (paused !== 1'b0 || pc !== 32'h78) begin fails++; $display("FAIL stall_no_pause: got p=%b pc=%h want 0 78", paused, pc); end
    stall = 1'b0;
    tick();
    tests++; if (paused !== 1'b1) begin fails++; $display("FAIL stall_pause: got %b want 1", paused); end
    stall = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    tick(6);
    tests++; if (pc !== 32'h78 || paused !== 1'b1) begin fails++; $display("FAIL stall_hold: got pc=%h p=%b want 78 1", pc, paused); end
    stall = 1'b0;
    #1;
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL pend_en: got %b want 1", pc_en); end
    tick();
    syscall = 1'b0;
    tests++; if (pc !== 32'h7C || paused !== 1'b0 || instr_cnt !== 32'd33 || cycle_cnt !== 32'd36) begin
      fails++; $display("FAIL pend_resume: got pc=%h p=%b i=%0d c=%0d want 7c 0 33 36", pc, paused, instr_cnt, cycle_cnt); end
  endtask

  task automatic test_cnt_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(17);
    tests++; if (pc_w !== 32'h3C) begin fails++; $display("FAIL wrap_pc: got %h want %h", pc_w, 32'h3C); end
    tests++; if (instr_w !== 4'd1 || cycle_w !== 4'd1 || xfer_w !== 4'd0) begin
      fails++; $display("FAIL wrap_cnts: got c=%0d i=%0d x=%0d want 1 1 0", cycle_w, instr_w, xfer_w); end
    tests++; if (pc !== 32'h44 || instr_cnt !== 32'd17) begin fails++; $display("FAIL wide_cnts: got pc=%h i=%0d want 44 17", pc, instr_cnt); end
  endtask

  task automatic test_rst_pause();
    syscall = 1'b1; sys_code = 32'h0A;
    tick();
    tests++; if (paused_w !== 1'b1 || pc_w !== 32'h3C) begin fails++; $display("FAIL rp_pause: got p=%b pc=%h want 1 3c", paused_w, pc_w); end
    stall = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    tests++; if (paused !== 1'b0 || pc !== 32'h0 || pc_w !== 32'hFFFF_FFF8 || pc_en !== 1'b0) begin
      fails++; $display("FAIL rp_reset: got p=%b pc=%h pcw=%h en=%b want 0 0 fffffff8 0", paused, pc, pc_w, pc_en); end
    tests++; if (cycle_w !== 4'd0 || instr_w !== 4'd0 || instr_cnt !== 32'd0) begin
      fails++; $display("FAIL rp_cnts: got cw=%0d iw=%0d i=%0d want 0 0 0", cycle_w, instr_w, instr_cnt); end
    rst = 1'b0; stall = 1'b0;
    tick();
    tests++; if (paused !== 1'b1 || pc_en !== 1'b0 || pc !== 32'h0) begin
      fails++; $display("FAIL rp_pend_cleared: got p=%b en=%b pc=%h want 1 0 0", paused, pc_en, pc); end
    tick();
    tests++; if (pc !== 32'h0 || paused !== 1'b1) begin fails++; $display("FAIL rp_stay: got pc=%h p=%b want 0 1", pc, paused); end
    syscall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_transfers();
    test_syscall_cont();
    test_pause_go();
    test_go_held();
    test_stall_pause();
    test_cnt_wrap();
    test_rst_pause();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the MIPS datapath.
- Owns the PC register, the next-PC selection (sequential, branch, jump, jr) and the syscall pause/resume handshake with the board's go button.
- Keeps performance counters for cycles, retired instructions and taken control transfers.
- Feeds the instruction ROM address and the link value (pc_plus4) to the writeback path.

Parameters:
- ADDR_W, 32, PC width in bits (range 8..32).
- RESET_PC, 0, PC value loaded on reset.
- CONT_CODE, 32'h00000022, syscall code that continues without pausing.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  external hold; PC and state frozen while high
- syscall  in  1  current instruction is syscall
- sys_code  in  32  syscall code register value
- go  in  1  asynchronous level from the go button
- branch_taken  in  1  conditional branch resolved taken
- jump  in  1  j/jal
- jr  in  1  jr
- instr_index  in  26  jump target field
- branch_off  in  32  sign-extended offset, already shifted left 2
- jr_target  in  ADDR_W  register jump target
- pc  out  ADDR_W  current PC (ROM address)
- pc_plus4  out  ADDR_W  pc+4, combinational, for link writeback
- pc_en  out  1  PC updates on this edge (instruction retires)
- paused  out  1  high in PAUSED state
- cycle_cnt  out  CNT_W  cycles spent in RUN
- instr_cnt  out  CNT_W  retired instructions
- xfer_cnt  out  CNT_W  retired non-sequential transfers

Behaviour:
- Reset, synchronous on rst=1 at a rising edge:
  - pc=RESET_PC, state=RUN.
  - All counters, go synchroniser flops and pend_go cleared.
  - pc_en=0 during reset cycles.
- States: RUN, PAUSED (2-state FSM).
- halt_req = syscall & (sys_code != CONT_CODE).
- go path:
  - go is shifted through g1,g2,g3.
  - go_rise = g2 & ~g3, high exactly one cycle per low-to-high transition.
  - Holding go high produces no further go_rise.
- pc_en is combinational:
  - RUN: ~stall & ~halt_req.
  - PAUSED: ~stall & (go_rise | pend_go).
- Transitions:
  - RUN -> PAUSED when ~stall & halt_req.
  - PAUSED -> RUN when pc_en.
- pend_go:
  - Set when go_rise occurs in PAUSED with stall=1.
  - Cleared when consumed by pc_en.
  - A go_rise seen in RUN is discarded; it does not pre-arm a later pause.
- Next PC when pc_en, priority jr > jump > branch_taken > sequential:
  - jr: jr_target.
  - jump: {pc_plus4[ADDR_W-1:28], instr_index, 2'b00}, truncated to ADDR_W.
  - branch: pc_plus4 + branch_off[ADDR_W-1:0].
  - sequential: pc_plus4.
  - Resuming from PAUSED is always sequential; all select inputs are ignored.
- Arithmetic is modulo 2^ADDR_W, so pc wraps silently.
- Counters wrap modulo 2^CNT_W:
  - cycle_cnt +1 on every non-reset edge with state=RUN.
  - instr_cnt +1 on every edge with pc_en.
  - xfer_cnt +1 on every edge with pc_en & (jr|jump|branch_taken) & state=RUN.
- stall=1: pc, state and instr_cnt/xfer_cnt hold; cycle_cnt still counts in RUN.
- rst mid-pause returns to RUN and discards pend_go.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {RUN, PAUSED}.
  - npc_sel encoding {SEQ, BR, J, JR}.
  - Default CONT_CODE constant.
- One sub-module, go_edge_sync: 3-flop synchroniser plus rising-edge detect, sync reset, output go_rise.

Test Plan:
- Reset then 4 idle cycles, no control inputs: pc = 0,4,8,12; instr_cnt=4; cycle_cnt=4; xfer_cnt=0.
- At pc=0x10: branch_off=0xFFFFFFF8 & branch_taken -> next pc=0x0C. Same cycle with jr=1, jr_target=0x40 -> pc=0x40 (jr wins); xfer_cnt +1.
- syscall with sys_code=0x22 at pc=0x20 -> pc=0x24 next edge, paused stays 0.
- syscall with sys_code=0x0A at pc=0x20:
  - pc holds 0x20 and paused=1.
  - go pulse -> pc=0x24 on the 3rd edge after go is first sampled high.
  - go held high 20 cycles afterwards, then a second halting syscall -> stays paused until go drops and rises again.
- In PAUSED, assert stall, pulse go, hold stall 5 more cycles -> pc unchanged; on the first edge with stall=0, pc advances by 4 and paused=0.
- CNT_W=4, run 17 sequential instructions -> instr_cnt=1. Apply rst while paused -> pc=RESET_PC, paused=0, counters 0.
